// File: rtl/hack_pkg.sv
// Shared constants and loader state encoding for the Hack RAM boot loader.
package hack_pkg;

  localparam int WORD_W = 16;
  localparam int ADDR_W = 7;
  localparam int DEPTH  = 128;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// Holds the low byte of a pair and registers the little-endian 16-bit word
// when the high byte arrives; the word is held until the next pair.
module byte_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        low_we,
  input  logic        high_we,
  output logic [15:0] word
);

  logic [7:0]  low_q,  low_d;
  logic [15:0] word_q, word_d;

  always_comb begin
    low_d  = low_q;
    word_d = word_q;
    if (low_we)  low_d  = byte_data;
    if (high_we) word_d = {byte_data, low_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      low_q  <= 8'd0;
      word_q <= 16'd0;
    end else begin
      low_q  <= low_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/ram_loader.sv
// Boot loader: packs a byte stream into words and writes them to consecutive
// RAM addresses. Define RAM_LOADER_CHECKSUM_EN for a trailing checksum byte.
//
// state | meaning
// IDLE  | waiting for start; CPU owns the RAM
// LOW   | waiting for the low byte of the next word
// HIGH  | waiting for the high byte of the next word
// WRITE | one-cycle RAM write of the assembled word
// CHECK | waiting for the checksum byte (checksum build only)
// DONE  | one-cycle completion pulse
module ram_loader #(
  parameter int WORD_W = hack_pkg::WORD_W,
  parameter int ADDR_W = hack_pkg::ADDR_W,
  parameter int DEPTH  = hack_pkg::DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        len,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [WORD_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_add,
  output logic              write,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  import hack_pkg::*;

  localparam logic [7:0]        DEPTH_B   = 8'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(DEPTH - 1);

  ld_state_t         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] add_q, add_d;
  logic [7:0]        len_m1;
  logic              accept;
  logic              low_we, high_we;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic [7:0] chk_total;
  logic       err_q, err_d;
`endif

  assign len_m1 = len - 8'd1;
  assign accept = byte_valid & byte_ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    add_d   = add_q;
    low_we  = 1'b0;
    high_we = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err_q;
    chk_total = sum_q + byte_data;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOW;
          ptr_d   = '0;
          // 0 and anything beyond the RAM size both mean "fill the whole RAM"
          last_d  = (len == 8'd0 || len > DEPTH_B) ? LAST_FULL : len_m1[ADDR_W-1:0];
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LOW: begin
        if (accept) begin
          low_we  = 1'b1;
          state_d = ST_HIGH;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = chk_total;
`endif
        end
      end
      ST_HIGH: begin
        if (accept) begin
          high_we = 1'b1;
          add_d   = ptr_q;
          state_d = ST_WRITE;
`ifdef RAM_LOADER_CHECKSUM_EN
          sum_d   = chk_total;
`endif
        end
      end
      ST_WRITE: begin
        if (ptr_q == last_q) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
`endif
        end else begin
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = ST_LOW;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          err_d   = (chk_total != 8'd0);
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      add_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      add_q   <= add_d;
    end
  end

`ifdef RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  byte_packer u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .byte_data (byte_data),
    .low_we    (low_we),
    .high_we   (high_we),
    .word      (ram_in)
  );

  assign ram_add    = add_q;
  assign write      = (state_q == ST_WRITE);
  assign byte_ready = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_CHECK);
  assign busy       = (state_q != ST_IDLE);
  assign cpu_hold   = busy;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: table-driven random loads against a
// word-packing model, plus hand-written reset, busy-start and checksum cases.
module tb_ram_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ram_in;
  logic [6:0]  ram_add;
  logic        write;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  always #5 clock = ~clock;

  ram_loader dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .len        (len),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ram_in     (ram_in),
    .ram_add    (ram_add),
    .write      (write),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          hold_bad = 0;
  int          got_addr[$];
  int          got_data[$];
  logic [15:0] ram_m [128];
  logic [7:0]  bytes_a [256];

  typedef struct {
    int len;
    int gap;
    int exp_n;
  } vec_t;

  vec_t vecs[8];

  // RAM model and write log, sampled mid-cycle
  always @(negedge clock) begin
    if (write) begin
      got_addr.push_back(int'(ram_add));
      got_data.push_back(int'(ram_in));
      ram_m[ram_add] = ram_in;
    end
    if (done) done_cnt++;
    if (cpu_hold !== busy) hold_bad++;
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic prep();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  task automatic randomize_bytes();
    foreach (bytes_a[i]) bytes_a[i] = 8'($urandom);
  endtask

  task automatic do_start(int l);
    @(negedge clock);
    start = 1'b1;
    len   = 8'(l);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b, int gap);
    int g;
    int tmo;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    byte_valid = 1'b0;
    repeat (g) @(negedge clock);
    byte_data  = b;
    byte_valid = 1'b1;
    tmo = 0;
    while (!byte_ready && tmo < 200) begin
      @(negedge clock);
      tmo++;
    end
    if (tmo >= 200) chk("ready_timeout", 0, 1);
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int tmo;
    tmo = 0;
    while (busy && tmo < 1000) begin
      @(negedge clock);
      tmo++;
    end
    if (tmo >= 1000) chk("idle_timeout", 0, 1);
  endtask

  // Sends bytes_a[first..last-1]; checksum builds append a trailer over bytes 0..last-1
  task automatic stream(int first, int last, int gap, bit bad);
    for (int i = first; i < last; i++) send_byte(bytes_a[i], gap);
`ifdef RAM_LOADER_CHECKSUM_EN
    begin
      logic [7:0] s;
      logic [7:0] c;
      s = 8'd0;
      for (int i = 0; i < last; i++) s = s + bytes_a[i];
      c = 8'd0 - s + {7'd0, bad};
      send_byte(c, gap);
    end
`else
    if (bad) chk("bad_checksum_unsupported", 0, 1);
`endif
    wait_idle();
  endtask

  // Model: word i lands at address i as {byte 2i+1, byte 2i}
  task automatic check_load(string nm, int exp_n);
    chk({nm, "_nwrites"}, got_addr.size(), exp_n);
    for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), got_addr[i], i);
      chk($sformatf("%s_data%0d", nm, i), got_data[i], int'({bytes_a[2*i+1], bytes_a[2*i]}));
    end
    chk({nm, "_done"}, done_cnt, 1);
    chk({nm, "_err"}, int'(err), 0);
  endtask

  initial begin
    vecs[0] = '{len: 2,   gap: 0,  exp_n: 2};
    vecs[1] = '{len: 1,   gap: 0,  exp_n: 1};
    vecs[2] = '{len: 5,   gap: 3,  exp_n: 5};
    vecs[3] = '{len: 0,   gap: 0,  exp_n: 128};
    vecs[4] = '{len: 200, gap: 0,  exp_n: 128};
    vecs[5] = '{len: 128, gap: 0,  exp_n: 128};
    vecs[6] = '{len: 129, gap: -1, exp_n: 128};
    vecs[7] = '{len: 127, gap: 0,  exp_n: 127};

    reset_n    = 1'b0;
    start      = 1'b0;
    len        = 8'd0;
    byte_data  = 8'd0;
    byte_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", int'({byte_ready, write, ram_add, ram_in, busy, cpu_hold, done, err}), 0);
    reset_n = 1'b1;

    // Basic load, back-to-back and with 3-cycle valid gaps
    for (int g = 0; g <= 3; g += 3) begin
      prep();
      bytes_a[0] = 8'h2D; bytes_a[1] = 8'h00;
      bytes_a[2] = 8'h32; bytes_a[3] = 8'h00;
      do_start(2);
      stream(0, 4, g, 1'b0);
      check_load($sformatf("basic_gap%0d", g), 2);
      chk($sformatf("basic_gap%0d_ram0", g), int'(ram_m[0]), 45);
      chk($sformatf("basic_gap%0d_ram1", g), int'(ram_m[1]), 50);
    end

    foreach (vecs[k]) begin
      prep();
      randomize_bytes();
      do_start(vecs[k].len);
      stream(0, 2 * vecs[k].exp_n, vecs[k].gap, 1'b0);
      check_load($sformatf("vec%0d_len%0d", k, vecs[k].len), vecs[k].exp_n);
    end

    // Reset after the low byte of word 1
    prep();
    randomize_bytes();
    do_start(2);
    for (int i = 0; i < 3; i++) send_byte(bytes_a[i], 0);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({byte_ready, write, ram_add, ram_in, busy, cpu_hold, done, err}), 0);
    chk("midrst_writes_before", got_addr.size(), 1);
    @(negedge clock);
    reset_n = 1'b1;
    prep();
    bytes_a[0] = 8'h01;
    bytes_a[1] = 8'h00;
    do_start(1);
    stream(0, 2, 0, 1'b0);
    check_load("midrst_reload", 1);
    chk("midrst_ram0", int'(ram_m[0]), 1);

    // start pulse with a different len while in HIGH must be ignored
    prep();
    randomize_bytes();
    do_start(3);
    send_byte(bytes_a[0], 0);
    start = 1'b1;
    len   = 8'd1;
    @(negedge clock);
    start = 1'b0;
    stream(1, 6, 0, 1'b0);
    check_load("busy_start", 3);

`ifdef RAM_LOADER_CHECKSUM_EN
    for (int b = 0; b < 2; b++) begin
      prep();
      bytes_a[0] = 8'h2D;
      bytes_a[1] = 8'h00;
      do_start(1);
      send_byte(8'h2D, 0);
      send_byte(8'h00, 0);
      send_byte((b == 0) ? 8'hD3 : 8'h00, 0);
      wait_idle();
      chk($sformatf("cksum%0d_nwrites", b), got_addr.size(), 1);
      chk($sformatf("cksum%0d_done", b), done_cnt, 1);
      chk($sformatf("cksum%0d_err", b), int'(err), b);
      repeat (2) @(negedge clock);
      chk($sformatf("cksum%0d_err_hold", b), int'(err), b);
    end
    do_start(1);
    chk("cksum_err_clear_on_start", int'(err), 0);
    stream(0, 2, 0, 1'b0);
`endif

    chk("cpu_hold_equals_busy", hold_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
